reorder_buffer: RTL and testbench

Circular reorder buffer that allocates entries at issue, collects results from execution units, and retires them in program order. It is the ROB-side master of the register file's commit and flush interface. It drives `write_en`/`reg_id`/`rob_id`/`value` and `clear_all`, and hands the allocated tag to the decoder for rename. It also answers decoder operand queries for busy registers and triggers a pipeline redirect when a mispredicted branch retires.

---
 rtl/reorder_buffer_pkg.sv | 38 +++
 rtl/reorder_buffer_if.sv | 14 +
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry layout and operand-query helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 3;
  localparam int REG_ID_BIT    = 5;
  localparam int ROB_WIDTH     = 1 << ROB_WIDTH_BIT;
  localparam int CNT_BIT       = ROB_WIDTH_BIT + 1;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;
  typedef logic [REG_ID_BIT-1:0]    reg_id_t;
  typedef logic [CNT_BIT-1:0]       rob_cnt_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        has_rd;
    reg_id_t     rd;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  // An entry answers a query once it holds a result or is being completed right now.
  function automatic logic query_ready(rob_entry_t e, logic wb_hit);
    return e.busy && (e.ready || wb_hit);
  endfunction

  // A same-cycle broadcast takes priority over the stored result; not-ready reads as zero.
  function automatic logic [31:0] query_value(rob_entry_t e, logic wb_hit, logic [31:0] wb_value);
    logic [31:0] result;
    result = '0;
    if (query_ready(e, wb_hit)) begin
      result = wb_hit ? wb_value : e.value;
    end
    return result;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Commit and flush bus between the reorder buffer and the register file.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        write_en;
  reg_id_t     reg_id;
  rob_id_t     rob_id;
  logic [31:0] value;
  logic        clear_all;

  modport master (output write_en, reg_id, rob_id, value, clear_all);
  modport slave  (input  write_en, reg_id, rob_id, value, clear_all);

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at issue, collects results, retires in
// program order and flushes everything when a mispredicted branch retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  // Must be a power of two no larger than ROB_WIDTH.
  parameter int DEPTH = ROB_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             issue_en,
  input  logic             issue_has_rd,
  input  reg_id_t          issue_rd,
  output rob_id_t          alloc_id,
  output logic             full,
  input  logic             wb_en,
  input  rob_id_t          wb_id,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  rob_id_t          q1_id,
  input  rob_id_t          q2_id,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value,
  output logic             redirect_en,
  output logic [31:0]      redirect_pc,
  reorder_buffer_if.master commit_bus
);

  rob_entry_t entries [DEPTH];
  rob_id_t    head;
  rob_id_t    tail;
  rob_cnt_t   count;

  rob_entry_t head_entry;
  logic       do_issue;
  logic       do_commit;
  logic       do_flush;

  function automatic rob_id_t next_ptr(rob_id_t p);
    return (p == rob_id_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign alloc_id   = tail;
  assign full       = (count == rob_cnt_t'(DEPTH));
  assign head_entry = entries[head];
  assign do_issue   = issue_en && !full;
  assign do_commit  = head_entry.busy && head_entry.ready;
  assign do_flush   = do_commit && head_entry.mispredict;

  // Two identical operand-query muxes that also see the current writeback.
  always_comb begin
    q1_ready = query_ready(entries[q1_id], wb_en && (wb_id == q1_id));
    q2_ready = query_ready(entries[q2_id], wb_en && (wb_id == q2_id));
    q1_value = query_value(entries[q1_id], wb_en && (wb_id == q1_id), wb_value);
    q2_value = query_value(entries[q2_id], wb_en && (wb_id == q2_id), wb_value);
  end

  // Entry bookkeeping, in-order retirement and registered commit/flush pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      commit_bus.write_en  <= 1'b0;
      commit_bus.reg_id    <= '0;
      commit_bus.rob_id    <= '0;
      commit_bus.value     <= '0;
      commit_bus.clear_all <= 1'b0;
      redirect_en          <= 1'b0;
      redirect_pc          <= '0;
    end else begin
      commit_bus.write_en  <= 1'b0;
      commit_bus.clear_all <= 1'b0;
      redirect_en          <= 1'b0;

      if (rdy_in) begin
        if (do_commit) begin
          commit_bus.write_en <= head_entry.has_rd;
          commit_bus.reg_id   <= head_entry.rd;
          commit_bus.rob_id   <= head;
          commit_bus.value    <= head_entry.value;
        end

        if (do_flush) begin
          for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
          end
          head                 <= '0;
          tail                 <= '0;
          count                <= '0;
          commit_bus.clear_all <= 1'b1;
          redirect_en          <= 1'b1;
          redirect_pc          <= head_entry.target;
        end else begin
          if (wb_en && entries[wb_id].busy) begin
            entries[wb_id].ready      <= 1'b1;
            entries[wb_id].value      <= wb_value;
            entries[wb_id].mispredict <= wb_mispredict;
            entries[wb_id].target     <= wb_target;
          end

          if (do_issue) begin
            entries[tail].busy       <= 1'b1;
            entries[tail].ready      <= 1'b0;
            entries[tail].has_rd     <= issue_has_rd;
            entries[tail].rd         <= issue_rd;
            entries[tail].value      <= '0;
            entries[tail].mispredict <= 1'b0;
            entries[tail].target     <= '0;
            tail                     <= next_ptr(tail);
          end

          if (do_commit) begin
            entries[head].busy <= 1'b0;
            head               <= next_ptr(head);
          end

          case ({do_issue, do_commit})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  typedef struct {
    reg_id_t     rd;
    rob_id_t     id;
    logic [31:0] value;
  } commit_t;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_en;
  logic        issue_has_rd;
  reg_id_t     issue_rd;
  rob_id_t     alloc_id;
  logic        full;
  logic        wb_en;
  rob_id_t     wb_id;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target;
  rob_id_t     q1_id;
  rob_id_t     q2_id;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  int      checks;
  int      errors;
  commit_t sb [$];
  commit_t exp_c;

  reorder_buffer_if bus ();

  reorder_buffer #(.DEPTH(ROB_WIDTH)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .issue_en      (issue_en),
    .issue_has_rd  (issue_has_rd),
    .issue_rd      (issue_rd),
    .alloc_id      (alloc_id),
    .full          (full),
    .wb_en         (wb_en),
    .wb_id         (wb_id),
    .wb_value      (wb_value),
    .wb_mispredict (wb_mispredict),
    .wb_target     (wb_target),
    .q1_id         (q1_id),
    .q2_id         (q2_id),
    .q1_ready      (q1_ready),
    .q2_ready      (q2_ready),
    .q1_value      (q1_value),
    .q2_value      (q2_value),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .commit_bus    (bus.master)
  );

  // Free-running 10 ns clock.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expectCommit(input reg_id_t rd, input rob_id_t id, input logic [31:0] value);
    commit_t c;
    c.rd    = rd;
    c.id    = id;
    c.value = value;
    sb.push_back(c);
  endtask

  // Drives one cycle of issue/writeback, then returns the inputs to idle.
  task automatic applyStimulus(input logic iss, input logic has_rd, input reg_id_t rd,
                               input logic wb, input rob_id_t wid, input logic [31:0] wval,
                               input logic mis, input logic [31:0] tgt);
    issue_en      = iss;
    issue_has_rd  = has_rd;
    issue_rd      = rd;
    wb_en         = wb;
    wb_id         = wid;
    wb_value      = wval;
    wb_mispredict = mis;
    wb_target     = tgt;
    tick();
    issue_en      = 1'b0;
    wb_en         = 1'b0;
    wb_mispredict = 1'b0;
  endtask

  task automatic issueOne(input reg_id_t rd, input logic has_rd);
    applyStimulus(1'b1, has_rd, rd, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic writeBack(input rob_id_t id, input logic [31:0] val, input logic mis, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, id, val, mis, tgt);
  endtask

  task automatic doReset();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
  endtask

  // Every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (bus.write_en === 1'b1) begin
      checkOutput("sb_commit_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        exp_c = sb.pop_front();
        checkOutput("sb_reg_id", bus.reg_id, exp_c.rd);
        checkOutput("sb_rob_id", bus.rob_id, exp_c.id);
        checkOutput("sb_value", bus.value, exp_c.value);
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    issue_en      = 1'b0;
    issue_has_rd  = 1'b0;
    issue_rd      = '0;
    wb_en         = 1'b0;
    wb_id         = '0;
    wb_value      = '0;
    wb_mispredict = 1'b0;
    wb_target     = '0;
    q1_id         = '0;
    q2_id         = '0;
    repeat (2) tick();

    $display("[TB] reset state");
    checkOutput("rst_alloc_id", alloc_id, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_write_en", bus.write_en, 0);
    checkOutput("rst_clear_all", bus.clear_all, 0);
    checkOutput("rst_redirect_en", redirect_en, 0);
    checkOutput("rst_redirect_pc", redirect_pc, 0);
    checkOutput("rst_value", bus.value, 0);
    rst_n_in = 1'b1;
    tick();

    $display("[TB] single issue and commit");
    issueOne(5'd5, 1'b1);
    checkOutput("t1_alloc_id", alloc_id, 1);
    checkOutput("t1_q_busy_ready", q1_ready, 0);
    checkOutput("t1_q_busy_value", q1_value, 0);
    expectCommit(5'd5, 3'd0, 32'h1234);
    writeBack(3'd0, 32'h1234, 1'b0, '0);
    checkOutput("t1_no_early_commit", bus.write_en, 0);
    checkOutput("t1_q_stored_ready", q1_ready, 1);
    checkOutput("t1_q_stored_value", q1_value, 32'h1234);
    tick();
    checkOutput("t1_write_en", bus.write_en, 1);
    checkOutput("t1_reg_id", bus.reg_id, 5);
    checkOutput("t1_rob_id", bus.rob_id, 0);
    checkOutput("t1_value", bus.value, 32'h1234);
    tick();
    checkOutput("t1_pulse_end", bus.write_en, 0);

    $display("[TB] out-of-order completion");
    doReset();
    expectCommit(5'd1, 3'd0, 32'h20);
    issueOne(5'd1, 1'b1);
    expectCommit(5'd2, 3'd1, 32'h21);
    issueOne(5'd2, 1'b1);
    expectCommit(5'd3, 3'd2, 32'h22);
    issueOne(5'd3, 1'b1);
    writeBack(3'd2, 32'h22, 1'b0, '0);
    checkOutput("t2_hold_after_id2", bus.write_en, 0);
    writeBack(3'd0, 32'h20, 1'b0, '0);
    checkOutput("t2_hold_after_id0", bus.write_en, 0);
    writeBack(3'd1, 32'h21, 1'b0, '0);
    checkOutput("t2_commit0_en", bus.write_en, 1);
    checkOutput("t2_commit0_id", bus.rob_id, 0);
    tick();
    checkOutput("t2_commit1_en", bus.write_en, 1);
    checkOutput("t2_commit1_id", bus.rob_id, 1);
    tick();
    checkOutput("t2_commit2_en", bus.write_en, 1);
    checkOutput("t2_commit2_id", bus.rob_id, 2);
    tick();
    checkOutput("t2_drained", bus.write_en, 0);

    $display("[TB] full buffer");
    doReset();
    for (int i = 0; i < ROB_WIDTH - 1; i++) begin
      issueOne(reg_id_t'(i + 8), 1'b1);
    end
    checkOutput("t3_not_full_yet", full, 0);
    checkOutput("t3_alloc_7", alloc_id, 7);
    issueOne(5'd15, 1'b1);
    checkOutput("t3_full", full, 1);
    checkOutput("t3_tail_wrapped", alloc_id, 0);
    issueOne(5'd31, 1'b1);
    checkOutput("t3_extra_full", full, 1);
    checkOutput("t3_extra_alloc", alloc_id, 0);
    expectCommit(5'd8, 3'd0, 32'h100);
    applyStimulus(1'b1, 1'b1, 5'd30, 1'b1, 3'd0, 32'h100, 1'b0, '0);
    checkOutput("t3_wb_still_full", full, 1);
    issueOne(5'd20, 1'b1);
    checkOutput("t3_commit_en", bus.write_en, 1);
    checkOutput("t3_commit_id", bus.rob_id, 0);
    checkOutput("t3_after_commit_full", full, 0);
    checkOutput("t3_after_commit_alloc", alloc_id, 0);
    issueOne(5'd21, 1'b1);
    checkOutput("t3_refill_full", full, 1);
    checkOutput("t3_refill_alloc", alloc_id, 1);

    $display("[TB] mispredict flush");
    doReset();
    issueOne(5'd0, 1'b0);
    issueOne(5'd6, 1'b1);
    issueOne(5'd7, 1'b1);
    writeBack(3'd1, 32'h11, 1'b0, '0);
    writeBack(3'd2, 32'h12, 1'b0, '0);
    writeBack(3'd0, 32'h0, 1'b1, 32'h80);
    checkOutput("t4_no_flush_yet", bus.clear_all, 0);
    issueOne(5'd9, 1'b1);
    checkOutput("t4_clear_all", bus.clear_all, 1);
    checkOutput("t4_redirect_en", redirect_en, 1);
    checkOutput("t4_redirect_pc", redirect_pc, 32'h80);
    checkOutput("t4_write_en", bus.write_en, 0);
    checkOutput("t4_alloc_id", alloc_id, 0);
    checkOutput("t4_full", full, 0);
    q1_id = 3'd1;
    #1;
    checkOutput("t4_q_cleared", q1_ready, 0);
    tick();
    checkOutput("t4_clear_pulse_end", bus.clear_all, 0);
    checkOutput("t4_redirect_pulse_end", redirect_en, 0);

    $display("[TB] same-cycle query bypass");
    issueOne(5'd4, 1'b1);
    issueOne(5'd10, 1'b1);
    issueOne(5'd11, 1'b1);
    issueOne(5'd12, 1'b1);
    q1_id    = 3'd3;
    q2_id    = 3'd2;
    wb_en    = 1'b1;
    wb_id    = 3'd3;
    wb_value = 32'hAA;
    #1;
    checkOutput("t5_q1_bypass_ready", q1_ready, 1);
    checkOutput("t5_q1_bypass_value", q1_value, 32'hAA);
    checkOutput("t5_q2_not_ready", q2_ready, 0);
    checkOutput("t5_q2_zero", q2_value, 0);
    tick();
    wb_en = 1'b0;
    q2_id = 3'd3;
    #1;
    checkOutput("t5_q2_stored_ready", q2_ready, 1);
    checkOutput("t5_q2_stored_value", q2_value, 32'hAA);

    $display("[TB] pause");
    expectCommit(5'd4, 3'd0, 32'h44);
    writeBack(3'd0, 32'h44, 1'b0, '0);
    rdy_in = 1'b0;
    tick();
    checkOutput("t6_paused_no_commit", bus.write_en, 0);
    issue_en     = 1'b1;
    issue_has_rd = 1'b1;
    issue_rd     = 5'd13;
    tick();
    issue_en = 1'b0;
    checkOutput("t6_paused_no_commit2", bus.write_en, 0);
    checkOutput("t6_paused_alloc", alloc_id, 4);
    rdy_in = 1'b1;
    tick();
    checkOutput("t6_resume_commit", bus.write_en, 1);
    checkOutput("t6_resume_value", bus.value, 32'h44);
    expectCommit(5'd10, 3'd1, 32'h55);
    writeBack(3'd1, 32'h55, 1'b0, '0);
    checkOutput("t6_gap", bus.write_en, 0);
    tick();
    checkOutput("t6_commit_id1", bus.write_en, 1);
    rdy_in = 1'b0;
    tick();
    checkOutput("t6_pulse_not_repeated", bus.write_en, 0);
    rdy_in = 1'b1;

    $display("[TB] mid-run reset");
    rst_n_in = 1'b0;
    wb_en    = 1'b1;
    wb_id    = 3'd2;
    wb_value = 32'h66;
    tick();
    wb_en    = 1'b0;
    rst_n_in = 1'b1;
    checkOutput("t7_write_en", bus.write_en, 0);
    checkOutput("t7_reg_id", bus.reg_id, 0);
    checkOutput("t7_rob_id", bus.rob_id, 0);
    checkOutput("t7_value", bus.value, 0);
    checkOutput("t7_clear_all", bus.clear_all, 0);
    checkOutput("t7_redirect_en", redirect_en, 0);
    checkOutput("t7_redirect_pc", redirect_pc, 0);
    checkOutput("t7_alloc_id", alloc_id, 0);
    checkOutput("t7_full", full, 0);
    q1_id = 3'd3;
    #1;
    checkOutput("t7_q_empty", q1_ready, 0);
    repeat (3) tick();
    checkOutput("t7_no_commit_after", bus.write_en, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
